// File: rtl/pb_debounce.sv
// Debounces one raw active-low push-button into a clean level plus pressed/released pulses.
// Optional long-press pulse is compiled in when PB_LONG_PRESS_EN is defined.
module pb_debounce #(
    parameter int DB_CYCLES   = 50_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(LONG_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PB_n,
    output logic       pb_clean,
    output logic       pressed,
    output logic       released,
    output logic       long_press,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        HELD   = 2'd2,
        WAIT_R = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       r_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clean;
    logic             w_clean_nxt;
    logic             r_pressed;
    logic             w_pressed_nxt;
    logic             r_released;
    logic             w_released_nxt;
    logic             w_pb_s;

`ifdef PB_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

    logic r_long;
    logic w_long_nxt;
    logic r_long_done;
    logic w_long_done_nxt;
`endif

    // Flops hold raw PB_n samples; preset high so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], PB_n};
        end
    end

    assign w_pb_s = ~r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= REL;
            r_cnt      <= '0;
            r_clean    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
`ifdef PB_LONG_PRESS_EN
            r_long      <= 1'b0;
            r_long_done <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clean    <= w_clean_nxt;
            r_pressed  <= w_pressed_nxt;
            r_released <= w_released_nxt;
`ifdef PB_LONG_PRESS_EN
            r_long      <= w_long_nxt;
            r_long_done <= w_long_done_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_clean_nxt    = r_clean;
        w_pressed_nxt  = 1'b0;
        w_released_nxt = 1'b0;
`ifdef PB_LONG_PRESS_EN
        w_long_nxt      = 1'b0;
        w_long_done_nxt = r_long_done;
`endif
        case (r_state)
            REL: begin
                if (w_pb_s) begin
                    w_state_nxt = WAIT_P;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_P: begin
                if (!w_pb_s) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = HELD;
                    w_clean_nxt   = 1'b1;
                    w_pressed_nxt = 1'b1;
                    w_cnt_nxt     = '0;
`ifdef PB_LONG_PRESS_EN
                    w_long_done_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_pb_s) begin
                    w_state_nxt = WAIT_R;
                    w_cnt_nxt   = '0;
                end
`ifdef PB_LONG_PRESS_EN
                // The done flag stops a bounce back into HELD from firing a second long press.
                else if (r_cnt == LONG_LAST) begin
                    w_long_nxt      = ~r_long_done;
                    w_long_done_nxt = 1'b1;
                    w_cnt_nxt       = LONG_SAT;
                end else if (r_cnt != LONG_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            WAIT_R: begin
                if (w_pb_s) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt    = REL;
                    w_clean_nxt    = 1'b0;
                    w_released_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign pb_clean    = r_clean;
    assign pressed     = r_pressed;
    assign released    = r_released;
    assign o_dbg_state = r_state;
`ifdef PB_LONG_PRESS_EN
    assign long_press  = r_long;
`else
    assign long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: directed edge-exact checks plus random bouncing against a
// run-length model of the debouncer; long-press expectations follow PB_LONG_PRESS_EN.
`timescale 1ns/1ps
module tb_pb_debounce;

    localparam int DB   = 4;
    localparam int LONG = 20;
`ifdef PB_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       PB_n  = 1'b1;
    logic       pb_clean;
    logic       pressed;
    logic       released;
    logic       long_press;
    logic [1:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pb_debounce #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PB_n       (PB_n),
        .pb_clean   (pb_clean),
        .pressed    (pressed),
        .released   (released),
        .long_press (long_press),
        .o_dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pb_clean flips once pb_s has disagreed with it for DB+1 consecutive edges.
    // long_press fires on the LONG-th consecutive pressed edge in the held level.
    logic [3:0] exp_q[$];
    bit         m_hist[$];
    bit         m_clean;
    bit         m_prev_s;
    bit         m_long_done;
    int         m_run;
    int         m_hold;

    always @(posedge clk or negedge rst_n) begin
        bit pb_s;
        bit e_pr;
        bit e_rel;
        bit e_long;
        if (!rst_n) begin
            m_clean     = 1'b0;
            m_prev_s    = 1'b0;
            m_long_done = 1'b0;
            m_run       = 0;
            m_hold      = 0;
            m_hist.delete();
            m_hist.push_back(1'b1);
            m_hist.push_back(1'b1);
            exp_q.delete();
        end else begin
            pb_s   = ~m_hist.pop_front();
            m_hist.push_back(PB_n);
            e_pr   = 1'b0;
            e_rel  = 1'b0;
            e_long = 1'b0;
            m_run  = (pb_s != m_clean) ? m_run + 1 : 0;
            if (m_run == DB + 1) begin
                m_clean = ~m_clean;
                m_run   = 0;
                m_hold  = 0;
                if (m_clean) begin
                    e_pr        = 1'b1;
                    m_long_done = 1'b0;
                end else begin
                    e_rel = 1'b1;
                end
            end else if (m_clean) begin
                m_hold = (pb_s && m_prev_s) ? m_hold + 1 : 0;
                if (LP_EN && m_hold == LONG && !m_long_done) begin
                    e_long      = 1'b1;
                    m_long_done = 1'b1;
                end
            end
            m_prev_s = pb_s;
            exp_q.push_back({m_clean, e_pr, e_rel, e_long});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [3:0] exp_v;
        if (!rst_n || exp_q.size() == 0) exp_v = 4'b0000;
        else exp_v = exp_q.pop_front();
        check("model_cmp clean/pr/rel/long", {pb_clean, pressed, released, long_press}, exp_v);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [3:0] exp);
        check(name, {pb_clean, pressed, released, long_press}, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held with button already down; press must come 7 edges after release.
        PB_n  = 1'b0;
        rst_n = 1'b0;
        tick(3);
        chk_out("reset_state", 4'b0000);
        rst_n = 1'b1;
        tick(6);
        chk_out("t1_edge6_not_yet", 4'b0000);
        tick(1);
        chk_out("t1_edge7_pressed", 4'b1100);
        tick(1);
        chk_out("t1_edge8_pulse_gone", 4'b1000);

        // Held: long_press on edge 27 (20 after pressed), then never again.
        tick(18);
        chk_out("t4_edge26_no_long", 4'b1000);
        tick(1);
        chk_out("t4_edge27_long", {3'b100, LP_EN});
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_out("t4_after_long_quiet", 4'b1000);
        end
        PB_n = 1'b1;
        tick(6);
        chk_out("t4_rel_edge6", 4'b1000);
        tick(1);
        chk_out("t4_rel_edge7_released", 4'b0010);
        tick(1);
        chk_out("t4_rel_edge8_pulse_gone", 4'b0000);

        // Clean press and release.
        PB_n = 1'b0;
        tick(6);
        chk_out("t2_edge6", 4'b0000);
        tick(1);
        chk_out("t2_edge7_pressed", 4'b1100);
        tick(1);
        chk_out("t2_edge8", 4'b1000);
        PB_n = 1'b1;
        tick(8);
        chk_out("t2_released_idle", 4'b0000);

        // Bounce of 3 cycles is rejected.
        PB_n = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) PB_n = 1'b1;
            tick(1);
            chk_out("t3_bounce_rejected", 4'b0000);
        end

        // Release lands on the edge the hold count would expire: no long_press.
        PB_n = 1'b0;
        tick(7);
        chk_out("t5_pressed", 4'b1100);
        tick(17);
        PB_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk_out("t5_no_long", 4'b1000);
        end
        tick(1);
        chk_out("t5_released", 4'b0010);
        tick(4);

        // Reset mid WAIT_P.
        PB_n = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst_waitp", 4'b0000);
        PB_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_out("t6_after_rst_waitp", 4'b0000);
        end

        // Reset on the cycle of an in-flight pressed pulse, then mid HELD.
        PB_n = 1'b0;
        tick(7);
        chk_out("t6_pressed_before_rst", 4'b1100);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst_inflight", 4'b0000);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk_out("t6_held_again", 4'b1000);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst_held", 4'b0000);
        PB_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_out("t6_after_rst_held", 4'b0000);
        end

        // Random bouncing, long holds and occasional resets against the model.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            if ($urandom_range(0, 3) != 0) PB_n = ~PB_n;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 10);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(len);
        end

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
